// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the IF redirect controller:
// redirect state encoding, address type and reset/exception vectors.
package pipeline_pkg;

  typedef logic [31:0] addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    EXC   = 2'd2
  } redirect_state_e;

  localparam addr_t BOOT_VECTOR         = 32'hBFC00000;
  localparam addr_t EXC_VECTOR_DEFAULT  = 32'hBFC00380;
  localparam int    STAT_W_DEFAULT      = 16;

endpackage

// File: rtl/if_redirect_ctrl_if.sv
// Redirect request/response bundle between ID/EX (master) and the IF redirect
// controller (slave). Counter outputs exist only with IF_REDIRECT_STATS_EN.
interface if_redirect_ctrl_if
  import pipeline_pkg::*;
`ifdef IF_REDIRECT_STATS_EN
  #(parameter int STAT_W = STAT_W_DEFAULT)
`endif
  ();

  logic  STALL_IN;
  logic  BranchValid_IN;
  addr_t BranchTarget_IN;
  logic  JumpRegValid_IN;
  addr_t JumpRegTarget_IN;
  logic  ExcValid_IN;
  logic  PCLoad_OUT;
  addr_t PCTarget_OUT;
  logic  Flush_OUT;
  logic  Busy_OUT;
`ifdef IF_REDIRECT_STATS_EN
  logic [STAT_W-1:0] BranchCount;
  logic [STAT_W-1:0] JumpRegCount;
  logic [STAT_W-1:0] ExcCount;
  logic [STAT_W-1:0] DroppedCount;
`endif

  modport master (
    output STALL_IN, BranchValid_IN, BranchTarget_IN,
           JumpRegValid_IN, JumpRegTarget_IN, ExcValid_IN,
    input  PCLoad_OUT, PCTarget_OUT, Flush_OUT, Busy_OUT
`ifdef IF_REDIRECT_STATS_EN
    , input BranchCount, JumpRegCount, ExcCount, DroppedCount
`endif
  );

  modport slave (
    input  STALL_IN, BranchValid_IN, BranchTarget_IN,
           JumpRegValid_IN, JumpRegTarget_IN, ExcValid_IN,
    output PCLoad_OUT, PCTarget_OUT, Flush_OUT, Busy_OUT
`ifdef IF_REDIRECT_STATS_EN
    , output BranchCount, JumpRegCount, ExcCount, DroppedCount
`endif
  );

endinterface

// File: rtl/if_redirect_stats.sv
// Bank of saturating event counters; one counter per bit of inc.
// Used by if_redirect_ctrl only when IF_REDIRECT_STATS_EN is defined.
module if_redirect_stats #(
  parameter int STAT_W = 16,
  parameter int N_CNT  = 4
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic [N_CNT-1:0]              inc,
  output logic [N_CNT-1:0][STAT_W-1:0]  count
);

  for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
    logic [STAT_W-1:0] cnt_q;
    logic [STAT_W-1:0] cnt_d;

    // Hold at all-ones instead of wrapping
    always_comb begin
      cnt_d = cnt_q;
      if (inc[gi] && !(&cnt_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign count[gi] = cnt_q;
  end

endmodule

// File: rtl/if_redirect_ctrl.sv
// Sequences branch, jump-register and exception redirects into IF as a single
// PC load pulse. Optional counters: define IF_REDIRECT_STATS_EN.
module if_redirect_ctrl
  import pipeline_pkg::*;
#(
  parameter addr_t EXC_VECTOR = EXC_VECTOR_DEFAULT
`ifdef IF_REDIRECT_STATS_EN
  , parameter int  STAT_W     = STAT_W_DEFAULT
`endif
) (
  input  logic            CLOCK,
  input  logic            RESET,
  if_redirect_ctrl_if.slave rd
);

  redirect_state_e state_q, state_d;
  addr_t           target_q, target_d;

  // Exception overrides everything, even a stall; branch/JR only sampled in
  // unstalled IDLE, so a branch sitting in a delay slot is simply ignored.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    if (rd.ExcValid_IN) begin
      state_d  = EXC;
      target_d = EXC_VECTOR;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!rd.STALL_IN) begin
            if (rd.JumpRegValid_IN) begin
              state_d  = ARMED;
              target_d = rd.JumpRegTarget_IN;
            end else if (rd.BranchValid_IN) begin
              state_d  = ARMED;
              target_d = rd.BranchTarget_IN;
            end
          end
        end
        ARMED, EXC: begin
          if (!rd.STALL_IN) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  assign rd.PCLoad_OUT   = (state_q != IDLE) && !rd.STALL_IN;
  assign rd.PCTarget_OUT = target_q;
  assign rd.Flush_OUT    = (state_q == EXC);
  assign rd.Busy_OUT     = (state_q != IDLE);

`ifdef IF_REDIRECT_STATS_EN
  logic                   idle_take;
  logic [3:0]             stat_inc;
  logic [3:0][STAT_W-1:0] stat_count;

  assign idle_take   = (state_q == IDLE) && !rd.STALL_IN && !rd.ExcValid_IN;
  assign stat_inc[0] = idle_take && rd.BranchValid_IN && !rd.JumpRegValid_IN;
  assign stat_inc[1] = idle_take && rd.JumpRegValid_IN;
  assign stat_inc[2] = rd.ExcValid_IN;
  assign stat_inc[3] = (state_q == ARMED) && (rd.BranchValid_IN || rd.JumpRegValid_IN);

  if_redirect_stats #(.STAT_W(STAT_W), .N_CNT(4)) u_stats (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .inc   (stat_inc),
    .count (stat_count)
  );

  assign rd.BranchCount  = stat_count[0];
  assign rd.JumpRegCount = stat_count[1];
  assign rd.ExcCount     = stat_count[2];
  assign rd.DroppedCount = stat_count[3];
`endif

endmodule
